// File: rtl/regfile_param_clr.sv
// Parametrised register file: two combinational read ports, one write port, post-reset clear engine.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_param_clr #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   RS1,
  input  logic [AW-1:0]   RS2,
  input  logic [AW-1:0]   RD,
  input  logic [XLEN-1:0] WriteData,
  input  logic            RegWrite,
  output logic [XLEN-1:0] ReadData1,
  output logic [XLEN-1:0] ReadData2,
  output logic            Busy
);
  localparam logic IDLE  = 1'b0;
  localparam logic CLEAR = 1'b1;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wr_en;
  logic            rd_zero;

  assign rd_zero = (ZERO_REG != 0) && (RD == '0);
  assign wr_en   = RegWrite && !busy_q && !reset && !rd_zero;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    regs_d    = regs_q;
    if (reset) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
      busy_d    = 1'b1;
    end else if (state_q == CLEAR) begin
      regs_d[clr_idx_q] = '0;
      clr_idx_d         = clr_idx_q + 1'b1;
      if (clr_idx_q == AW'(NREGS - 1)) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    end else if (wr_en) begin
      regs_d[RD] = WriteData;
    end
  end

  // Array has no reset: it is zeroed by the clear engine instead.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] rs);
    if (reset || busy_q)                   return '0;
    else if ((ZERO_REG != 0) && rs == '0)  return '0;
    else if (BYPASS && wr_en && rs == RD)  return WriteData;
    else                                   return regs_q[rs];
  endfunction

  assign ReadData1 = rd_port(RS1);
  assign ReadData2 = rd_port(RS2);
  assign Busy      = busy_q;
endmodule

// File: tb/tb_regfile_param_clr.sv
// Bench for regfile_param_clr: clear timing, table-driven read/write vectors, reset-restart.
module tb_regfile_param_clr;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RS1, RS2, RD;
  logic [63:0] WriteData;
  logic        RegWrite;
  logic [63:0] ReadData1, ReadData2, z_rd1, z_rd2;
  logic        Busy, z_busy;

  always #5 clk = ~clk;

  regfile_param_clr #(.XLEN(64), .NREGS(32), .AW(5), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .RS1(RS1), .RS2(RS2), .RD(RD), .WriteData(WriteData),
    .RegWrite(RegWrite), .ReadData1(ReadData1), .ReadData2(ReadData2), .Busy(Busy));

  regfile_param_clr #(.XLEN(64), .NREGS(32), .AW(5), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset(reset), .RS1(RS1), .RS2(RS2), .RD(RD), .WriteData(WriteData),
    .RegWrite(RegWrite), .ReadData1(z_rd1), .ReadData2(z_rd2), .Busy(z_busy));

  typedef struct {
    string       nm;
    logic [63:0] e1, e2, z2;
    logic        eb;
  } exp_t;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] wd;
    logic        we;
    logic [63:0] e1, e2, z2;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string nm, input logic [63:0] e1, input logic [63:0] e2,
                           input logic [63:0] z2, input logic eb);
    exp_t e;
    e.nm = nm; e.e1 = e1; e.e2 = e2; e.z2 = z2; e.eb = eb;
    sb.push_back(e);
  endtask

  task automatic check_rd();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.nm, "_rd1"}, ReadData1, e.e1);
    chk({e.nm, "_rd2"}, ReadData2, e.e2);
    chk({e.nm, "_z_rd2"}, z_rd2, e.z2);
    chk({e.nm, "_busy"}, {63'd0, Busy}, {63'd0, e.eb});
  endtask

  // Runs edges until Busy falls, checking reads stay 0; returns edge count.
  task automatic count_clear(input string nm, output int cnt);
    cnt = 0;
    while (Busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
      if (Busy === 1'b1 && (ReadData1 !== 64'd0 || ReadData2 !== 64'd0 || z_rd1 !== 64'd0)) begin
        chk({nm, "_rd_during_busy"}, ReadData1 | ReadData2 | z_rd1, 64'd0);
      end
    end
  endtask

  vec_t vt[10];
  int   cnt;

  initial begin
    vt[0] = '{5'd5,  5'd0,  5'd5,  64'hDEAD_BEEF, 1'b1, BYP ? 64'hDEAD_BEEF : 64'd0, 64'd0, 64'd0};
    vt[1] = '{5'd5,  5'd5,  5'd0,  64'd0,         1'b0, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'hDEAD_BEEF};
    vt[2] = '{5'd0,  5'd0,  5'd0,  64'h1234,      1'b1, 64'd0, 64'd0, BYP ? 64'h1234 : 64'd0};
    vt[3] = '{5'd0,  5'd0,  5'd0,  64'd0,         1'b0, 64'd0, 64'd0, 64'h1234};
    vt[4] = '{5'd7,  5'd5,  5'd3,  64'h11,        1'b1, 64'd0, 64'hDEAD_BEEF, 64'hDEAD_BEEF};
    vt[5] = '{5'd3,  5'd3,  5'd3,  64'h55,        1'b1, BYP ? 64'h55 : 64'h11, BYP ? 64'h55 : 64'h11,
              BYP ? 64'h55 : 64'h11};
    vt[6] = '{5'd3,  5'd3,  5'd0,  64'd0,         1'b0, 64'h55, 64'h55, 64'h55};
    vt[7] = '{5'd31, 5'd30, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              BYP ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0, 64'd0, 64'd0};
    vt[8] = '{5'd31, 5'd7,  5'd0,  64'd0,         1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0};
    vt[9] = '{5'd5,  5'd31, 5'd31, 64'hABC,       1'b1, 64'hDEAD_BEEF,
              BYP ? 64'hABC : 64'hFFFF_FFFF_FFFF_FFFF, BYP ? 64'hABC : 64'hFFFF_FFFF_FFFF_FFFF};

    reset = 1'b1; RegWrite = 1'b0; RS1 = 5'd5; RS2 = 5'd7; RD = 5'd0; WriteData = '0;
    tick();
    expect_rd("reset", 64'd0, 64'd0, 64'd0, 1'b1);
    check_rd();
    tick();
    reset = 1'b0;
    // Writes to reg 7 during the whole clear must be dropped.
    RegWrite = 1'b1; RD = 5'd7; WriteData = 64'hAA;
    count_clear("clr1", cnt);
    chk("clr1_edges", 64'(cnt), 64'd32);
    RegWrite = 1'b0;
    chk("clr1_z_busy", {63'd0, z_busy}, 64'd0);

    for (int i = 0; i < 10; i++) begin
      RS1 = vt[i].rs1; RS2 = vt[i].rs2; RD = vt[i].rd;
      WriteData = vt[i].wd; RegWrite = vt[i].we;
      expect_rd($sformatf("vec%0d", i), vt[i].e1, vt[i].e2, vt[i].z2, 1'b0);
      check_rd();
      tick();
    end
    RegWrite = 1'b0;

    // Reset pulse at clear cycle 10 restarts the full 32-edge clear.
    RS1 = 5'd5; RS2 = 5'd3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("restart_busy_mid", {63'd0, Busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_clear("clr2", cnt);
    chk("clr2_edges", 64'(cnt), 64'd32);
    RS2 = 5'd31;
    expect_rd("after_restart", 64'd0, 64'd0, 64'd0, 1'b0);
    check_rd();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
